// File: rtl/alu_addsub_seq.sv
// Multi-cycle signed adder/subtractor: adds CHUNK bits per cycle, LSB first, with
// valid/ready handshakes, optional saturation and OF/COUT/ZERO/NEG flags.
module alu_addsub_seq #(
    parameter int WIDTH  = 6,
    parameter int CHUNK  = 2,
    parameter int SAT_EN = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SEL,
    input  logic             SAT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             OF,
    output logic             COUT,
    output logic             ZERO,
    output logic             NEG
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST   = CW'(NCHUNK - 1);
    localparam logic             SAT_ON = (SAT_EN != 0);
    localparam logic [WIDTH-1:0] Y_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Y_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  bn_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              sat_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  y_r;
    logic              of_r;
    logic              cout_r;
    logic              zero_r;
    logic              neg_r;

    int                idx_s;
    logic [CHUNK:0]    slice_sum_s;
    logic [WIDTH-1:0]  sum_next_s;
    logic [WIDTH-1:0]  y_final_s;
    logic              of_s;
    logic              last_s;

    function automatic logic signed_overflow(input logic a_msb, input logic bn_msb,
                                             input logic s_msb);
        return (~a_msb & ~bn_msb & s_msb) | (a_msb & bn_msb & ~s_msb);
    endfunction

    // One chunk of the ripple sum, merged into the partial sum, plus final result selection
    always_comb begin
        idx_s       = int'(cnt_r) * CHUNK;
        slice_sum_s = {1'b0, a_r[idx_s +: CHUNK]} + {1'b0, bn_r[idx_s +: CHUNK]}
                      + {{CHUNK{1'b0}}, carry_r};
        sum_next_s  = sum_r;
        sum_next_s[idx_s +: CHUNK] = slice_sum_s[CHUNK-1:0];
        of_s        = signed_overflow(a_r[WIDTH-1], bn_r[WIDTH-1], sum_next_s[WIDTH-1]);
        last_s      = (cnt_r == LAST);
        if (sat_r && of_s) begin
            y_final_s = a_r[WIDTH-1] ? Y_MIN : Y_MAX;
        end else begin
            y_final_s = sum_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (IN_VALID) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, per-chunk accumulation and result/flag registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_r     <= '0;
            bn_r    <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            sat_r   <= 1'b0;
            cnt_r   <= '0;
            y_r     <= '0;
            of_r    <= 1'b0;
            cout_r  <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_r     <= A;
                        bn_r    <= SEL ? ~B : B;
                        carry_r <= SEL;
                        sat_r   <= SAT & SAT_ON;
                        sum_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                ST_BUSY: begin
                    sum_r   <= sum_next_s;
                    carry_r <= slice_sum_s[CHUNK];
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        y_r    <= y_final_s;
                        of_r   <= of_s;
                        cout_r <= slice_sum_s[CHUNK];
                        zero_r <= (y_final_s == '0);
                        neg_r  <= y_final_s[WIDTH-1];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Ready is gated by reset so no operation can be offered while the block is held
    assign IN_READY  = RST_N & (state_r == ST_IDLE);
    assign OUT_VALID = (state_r == ST_DONE);
    assign Y         = y_r;
    assign OF        = of_r;
    assign COUT      = cout_r;
    assign ZERO      = zero_r;
    assign NEG       = neg_r;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Randomised self-checking bench for alu_addsub_seq: a cycle-level reference model
// for the 6-bit instance plus literal spot checks, and a 16-bit instance for wide-chunk cases.
module tb_alu_addsub_seq;

    localparam int W  = 6;
    localparam int C  = 2;
    localparam int NC = W / C;
    localparam int W2 = 16;
    localparam int C2 = 4;
    localparam int NC2 = W2 / C2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          iv = 1'b0, ir, sel = 1'b0, sat = 1'b0, ov, ordy = 1'b0;
    logic [W-1:0]  a = '0, b = '0, y;
    logic          of, cout, zero, neg;

    logic          iv16 = 1'b0, ir16, sel16 = 1'b0, sat16 = 1'b0, ov16, ordy16 = 1'b0;
    logic [W2-1:0] a16 = '0, b16 = '0, y16;
    logic          of16, cout16, zero16, neg16;

    int vectors = 0;
    int miscompares = 0;

    alu_addsub_seq #(.WIDTH(W), .CHUNK(C), .SAT_EN(1)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(iv), .IN_READY(ir), .SEL(sel), .SAT(sat),
        .A(a), .B(b), .OUT_VALID(ov), .OUT_READY(ordy), .Y(y), .OF(of), .COUT(cout),
        .ZERO(zero), .NEG(neg)
    );

    alu_addsub_seq #(.WIDTH(W2), .CHUNK(C2), .SAT_EN(1)) dut16 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(iv16), .IN_READY(ir16), .SEL(sel16), .SAT(sat16),
        .A(a16), .B(b16), .OUT_VALID(ov16), .OUT_READY(ordy16), .Y(y16), .OF(of16),
        .COUT(cout16), .ZERO(zero16), .NEG(neg16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {cout, of, y[31:0]} for a w-bit operation
    function automatic logic [33:0] calc(input int w, input longint ua, input longint ub,
                                         input bit sel_i, input bit sat_i);
        longint one, full, maxv, minv, sa, sb, t, bn, yv;
        bit o, c;
        one  = 1;
        full = one << w;
        maxv = (full >> 1) - 1;
        minv = -(full >> 1);
        sa = (ua > maxv) ? ua - full : ua;
        sb = (ub > maxv) ? ub - full : ub;
        t  = sel_i ? sa - sb : sa + sb;
        o  = (t > maxv) || (t < minv);
        bn = sel_i ? (full - 1 - ub) : ub;
        c  = ((ua + bn + longint'(sel_i)) >= full);
        yv = (sat_i && o) ? ((sa < 0) ? (full >> 1) : maxv) : (t & (full - 1));
        return {c, o, yv[31:0]};
    endfunction

    // Cycle-level model of the 6-bit instance: idle / busy countdown / done
    int           m_state = 0;
    int           m_cnt = 0;
    logic [33:0]  p_res = '0;
    logic [W-1:0] m_y = '0;
    logic         m_of = 1'b0, m_cout = 1'b0, m_zero = 1'b0, m_neg = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state <= 0; m_cnt <= 0; m_y <= '0;
            m_of <= 1'b0; m_cout <= 1'b0; m_zero <= 1'b0; m_neg <= 1'b0;
        end else begin
            case (m_state)
                0: if (iv) begin
                    p_res   <= calc(W, longint'(a), longint'(b), sel, sat);
                    m_cnt   <= NC;
                    m_state <= 1;
                end
                1: if (m_cnt == 1) begin
                    m_state <= 2;
                    m_y     <= p_res[W-1:0];
                    m_of    <= p_res[32];
                    m_cout  <= p_res[33];
                    m_zero  <= (p_res[W-1:0] == '0);
                    m_neg   <= p_res[W-1];
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2: if (ordy) m_state <= 0;
                default: m_state <= 0;
            endcase
        end
    end

    // Every-cycle comparison of the 6-bit instance against the model
    always @(posedge clk) begin
        #1;
        check("cycle{ir,ov,of,cout,zero,neg,y}",
              {ir, ov, of, cout, zero, neg, y},
              {(m_state == 0) && rst_n, m_state == 2, m_of, m_cout, m_zero, m_neg, m_y});
    end

    task automatic op6(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit tsel,
                       input bit tsat, input int hold, input bit toggle, input bit lit,
                       input logic [W-1:0] ey, input logic [3:0] ef, input string nm);
        int n;
        @(negedge clk);
        ordy = 1'b0; a = ta; b = tb; sel = tsel; sat = tsat; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        n = 0;
        while (!ov && n < 20) begin
            if (toggle) begin
                a = W'($urandom); b = W'($urandom); sel = 1'($urandom); sat = 1'($urandom);
                iv = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, NC);
        if (lit) begin
            check({nm, "_y"}, y, ey);
            check({nm, "_of_cout_zero_neg"}, {of, cout, zero, neg}, ef);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (toggle) begin
                a = W'($urandom); b = W'($urandom); iv = 1'($urandom);
            end
        end
        if (lit) check({nm, "_y_held"}, y, ey);
        @(negedge clk);
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk);
    endtask

    task automatic op16(input logic [W2-1:0] ta, input logic [W2-1:0] tb, input bit tsel,
                        input bit tsat, input bit lit, input logic [W2-1:0] ey,
                        input logic [3:0] ef, input string nm);
        int n;
        logic [33:0] r;
        r = calc(W2, longint'(ta), longint'(tb), tsel, tsat);
        @(negedge clk);
        ordy16 = 1'b0; a16 = ta; b16 = tb; sel16 = tsel; sat16 = tsat; iv16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0; a16 = W2'($urandom); b16 = W2'($urandom);
        n = 0;
        while (!ov16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, NC2);
        check({nm, "_ir_low"}, ir16, 1'b0);
        check({nm, "_model"}, {cout16, of16, zero16, neg16, y16},
              {r[33], r[32], r[W2-1:0] == '0, r[W2-1], r[W2-1:0]});
        if (lit) begin
            check({nm, "_y"}, y16, ey);
            check({nm, "_of_cout_zero_neg"}, {of16, cout16, zero16, neg16}, ef);
        end
        @(negedge clk);
        ordy16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy16 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ir", ir, 1'b0);
        check("reset_y_ov", {ov, y}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ir_after_reset", ir, 1'b1);

        op6(6'd5,  6'd3,  1'b0, 1'b0, 0, 1'b0, 1'b1, 6'd8,  4'b0000, "T1");
        op6(6'd31, 6'd1,  1'b0, 1'b0, 1, 1'b0, 1'b1, 6'h20, 4'b1001, "T2_wrap");
        op6(6'd31, 6'd1,  1'b0, 1'b1, 0, 1'b0, 1'b1, 6'd31, 4'b1000, "T2_sat");
        op6(6'h20, 6'd1,  1'b1, 1'b0, 0, 1'b0, 1'b1, 6'd31, 4'b1100, "T3_wrap");
        op6(6'h20, 6'd1,  1'b1, 1'b1, 2, 1'b0, 1'b1, 6'h20, 4'b1101, "T3_sat");
        op6(6'd7,  6'd7,  1'b1, 1'b0, 0, 1'b0, 1'b1, 6'd0,  4'b0110, "T4_sub");
        op6(6'h3F, 6'd1,  1'b0, 1'b0, 0, 1'b0, 1'b1, 6'd0,  4'b0110, "T4_add");
        op6(6'd10, 6'h3D, 1'b0, 1'b0, 5, 1'b1, 1'b1, 6'd7,  4'b0100, "T5");

        // Reset during the second busy cycle aborts the operation
        @(negedge clk);
        ordy = 1'b0; a = 6'd9; b = 6'd4; sel = 1'b0; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("T6_ir_in_reset", ir, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("T6_after_release", {ir, ov, of, cout, zero, neg, y}, {1'b1, 11'd0});
        repeat (5) @(negedge clk);
        check("T6_no_result", {ov, y}, '0);

        op16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 4'b1000, "T7");
        op16(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 4'b1100, "T7_wrap");
        for (int i = 0; i < 20; i++) begin
            op16(W2'($urandom), W2'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, '0, "rand16");
        end

        for (int i = 0; i < 150; i++) begin
            op6(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'b1, 1'b0, '0, '0, "rand6");
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
